seq_shifter32: RTL

SEQ_SHIFTER32 -- requirements
Module: seq_shifter32

---
 rtl/seq_shifter32_pkg.sv | 21 ++
 rtl/seq_shifter32_shift_step.sv | 26 ++
 rtl/seq_shifter32.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_shifter32_pkg.sv
// Shared definitions for the sequential shifter.
//   - WIDTH_DEFAULT : default datapath width
//   - MODE_*        : aluc encodings (bit 0 selects left, bit 1 selects
//                     logical fill for right shifts)
//   - state_t       : controller state encoding
package seq_shifter32_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] MODE_SRA = 2'b00;  // arithmetic right
  localparam logic [1:0] MODE_SRL = 2'b10;  // logical right
  localparam logic [1:0] MODE_SLA = 2'b01;  // arithmetic left (same as SLL)
  localparam logic [1:0] MODE_SLL = 2'b11;  // logical left

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shifter32_shift_step.sv
// One-bit shift of a value in one of the four shifter modes (combinational).
//   value  : operand
//   mode   : aluc-style mode (see seq_shifter32_pkg)
//   result : value shifted by one position
module shift_step
  import seq_shifter32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so every path drives result; no latch.
    result = value;
    case (mode)
      MODE_SRA:           result = {value[WIDTH-1], value[WIDTH-1:1]};
      MODE_SRL:           result = {1'b0, value[WIDTH-1:1]};
      MODE_SLA, MODE_SLL: result = {value[WIDTH-2:0], 1'b0};
      default:            result = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter32.sv
// Sequential shifter: shifts a by b positions, one bit per clock.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled with a, b, aluc when not busy
//   a     : operand
//   b     : shift amount 0..31
//   aluc  : mode (00 SRA, 10 SRL, 01/11 left)
//   c     : registered result of the last completed operation
//   busy  : high while shifting
//   done  : one-cycle pulse when c has just been updated
module seq_shifter32
  import seq_shifter32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       b,
  input  logic [1:0]       aluc,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [1:0]       mode_r;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (work),
    .mode   (mode_r),
    .result (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is a handful of flops, so all of them,
      // working registers included, are cleared so an abandoned operation
      // leaves no trace.
      state  <= ST_IDLE;
      work   <= '0;
      mode_r <= MODE_SRA;
      cnt    <= '0;
      c      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later reads in this block
      // see the pre-edge values, which the transitions below rely on.
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work   <= a;
            mode_r <= aluc;
            if (b == 5'd0) begin
              // Zero shift completes immediately with a unchanged.
              c     <= a;
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt   <= b;
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // start and the operand inputs are ignored here.
          work <= step;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            c     <= step;
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
